// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the multi-channel MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} ch_state_t;

  // {min10, min1, sec10, sec1}
  typedef logic [15:0] mmss_t;

  localparam mmss_t MMSS_ZERO = 16'h0000;
  localparam mmss_t MMSS_ONE  = 16'h0001;

  // Two-digit BCD increment that wraps 59 -> 00 without carry-out.
  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    logic [7:0] r;
    if (v >= 8'h59)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic mmss_t bcd_dec_mmss(input mmss_t v);
    mmss_t r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = (v[15:12] != 4'd0) ? v[15:12] - 4'd1 : 4'd5;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: set/current MM:SS, run/pause/alarm sequencing, auto-reload.
//   state    | meaning
//   ST_IDLE  | stopped; set value editable and displayed
//   ST_RUN   | counting down once per tick
//   ST_PAUSE | count frozen, resumes from cur
//   ST_ALARM | expired; ring counter runs until ALARM_SEC or silenced
module timer_channel
  import timer_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        tick,
  input  logic        do_clear,
  input  logic        do_start,
  input  logic        do_inc_min,
  input  logic        do_inc_sec,
  input  logic        do_alarm_off,
  input  logic        reload_mode,
  output logic [15:0] disp,
  output logic        running,
  output logic        alarm,
  output logic        expired
);

  localparam int RING_W = $clog2(ALARM_SEC + 1);

  ch_state_t          state, state_nx;
  mmss_t              set_val, set_nx, cur, cur_nx;
  logic [RING_W-1:0]  ring, ring_nx;
  logic               pend, pend_nx, exp_nx;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= ST_IDLE;
      set_val <= MMSS_ZERO;
      cur     <= MMSS_ZERO;
      ring    <= '0;
      pend    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      set_val <= set_nx;
      cur     <= cur_nx;
      ring    <= ring_nx;
      pend    <= pend_nx;
      expired <= exp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    set_nx   = set_val;
    cur_nx   = cur;
    ring_nx  = ring;
    pend_nx  = 1'b0;
    exp_nx   = 1'b0;
    if (do_clear) begin
      state_nx = ST_IDLE;
    end else begin
      // Reload lands the cycle after expiry; a tick cannot collide with it.
      if (pend)
        cur_nx = set_val;
      case (state)
        ST_IDLE: begin
          if (do_start) begin
            if (set_val != MMSS_ZERO) begin
              cur_nx   = set_val;
              state_nx = ST_RUN;
            end
          end else if (do_inc_min) begin
            set_nx[15:8] = bcd_inc_60(set_val[15:8]);
          end else if (do_inc_sec) begin
            set_nx[7:0] = bcd_inc_60(set_val[7:0]);
          end
        end
        ST_RUN: begin
          if (do_start) begin
            state_nx = ST_PAUSE;
          end else if (tick && !pend) begin
            cur_nx = bcd_dec_mmss(cur);
            if (cur == MMSS_ONE) begin
              exp_nx = 1'b1;
              if (reload_mode) begin
                pend_nx = 1'b1;
              end else begin
                state_nx = ST_ALARM;
                ring_nx  = '0;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (do_start)
            state_nx = ST_RUN;
        end
        ST_ALARM: begin
          if (do_start || do_alarm_off) begin
            state_nx = ST_IDLE;
          end else if (tick) begin
            ring_nx = ring + 1'b1;
            if (ring_nx == RING_W'(ALARM_SEC))
              state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign disp    = (state == ST_IDLE) ? set_val : cur;
  assign running = (state == ST_RUN);
  assign alarm   = (state == ST_ALARM);

endmodule

// File: rtl/multi_timer.sv
// N-channel MM:SS countdown timer: shared second prescaler, per-channel command routing,
// selected-channel display mux and alarm buzzer tone.
module multi_timer
  import timer_pkg::*;
#(
  parameter int   N_CH      = 4,
  parameter int   TICK_DIV  = 100_000_000,
  parameter int   BUZZ_BIT  = 12,
  parameter int   ALARM_SEC = 10,
  localparam int  SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [SEL_W-1:0] sel_ch,
  input  logic             cmd_start,
  input  logic             cmd_inc_sec,
  input  logic             cmd_inc_min,
  input  logic             cmd_clear,
  input  logic             alarm_off,
  input  logic [N_CH-1:0]  reload_mode,
  output logic [15:0]      value,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  alarm,
  output logic [N_CH-1:0]  expired,
  output logic             buzz_clk
);

  // Wide enough to reach TICK_DIV-1 and to expose the buzzer tap.
  localparam int PS_W = ($clog2(TICK_DIV) > BUZZ_BIT + 1) ? $clog2(TICK_DIV) : BUZZ_BIT + 1;

  logic [PS_W-1:0] ps;
  logic            tick;
  logic            c_clear, c_start, c_inc_min, c_inc_sec, c_alarm_off;
  logic [15:0]     disp_arr [N_CH];

  assign tick = (ps == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      ps <= '0;
    else if (tick)
      ps <= '0;
    else
      ps <= ps + 1'b1;
  end

  // Only the highest-priority command of the cycle acts.
  always_comb begin
    c_clear     = cmd_clear;
    c_start     = cmd_start & ~cmd_clear;
    c_inc_min   = cmd_inc_min & ~cmd_clear & ~cmd_start;
    c_inc_sec   = cmd_inc_sec & ~cmd_clear & ~cmd_start & ~cmd_inc_min;
    c_alarm_off = alarm_off & ~cmd_clear & ~cmd_start & ~cmd_inc_min & ~cmd_inc_sec;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = (sel_ch == SEL_W'(i));

    timer_channel #(.ALARM_SEC(ALARM_SEC)) u_ch (
      .clk          (clk),
      .reset_p      (reset_p),
      .tick         (tick),
      .do_clear     (hit & c_clear),
      .do_start     (hit & c_start),
      .do_inc_min   (hit & c_inc_min),
      .do_inc_sec   (hit & c_inc_sec),
      .do_alarm_off (hit & c_alarm_off),
      .reload_mode  (reload_mode[i]),
      .disp         (disp_arr[i]),
      .running      (running[i]),
      .alarm        (alarm[i]),
      .expired      (expired[i])
    );
  end

  always_comb begin
    value = 16'h0000;
    for (int i = 0; i < N_CH; i++)
      if (sel_ch == SEL_W'(i))
        value = disp_arr[i];
  end

  assign buzz_clk = (|alarm) ? ps[BUZZ_BIT] : 1'b0;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus randomized commands against a seconds-based model.
module tb_multi_timer;

  localparam int N_CH = 4, TICK_DIV = 10, BUZZ_BIT = 2, ALARM_SEC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  localparam int K_NONE = 0, K_CLEAR = 1, K_START = 2, K_INC_MIN = 3, K_INC_SEC = 4, K_ALARM_OFF = 5;

  logic            clk = 1'b0;
  logic            reset_p = 1'b1;
  logic [1:0]      sel_ch = '0;
  logic            cmd_start = 0, cmd_inc_sec = 0, cmd_inc_min = 0, cmd_clear = 0, alarm_off = 0;
  logic [N_CH-1:0] reload_mode = '0;
  logic [15:0]     value;
  logic [N_CH-1:0] running, alarm, expired;
  logic            buzz_clk;

  int n_cmp = 0, n_err = 0;

  // reference model: set as separate min/sec, current as total seconds
  int m_state [N_CH];
  int m_smin  [N_CH];
  int m_ssec  [N_CH];
  int m_cur   [N_CH];
  int m_ring  [N_CH];
  bit m_pend  [N_CH];
  bit m_exp   [N_CH];
  int m_ps;
  bit m_tick;

  int exp_cnt [N_CH];
  bit buzz_hi, buzz_lo;

  multi_timer #(.N_CH(N_CH), .TICK_DIV(TICK_DIV), .BUZZ_BIT(BUZZ_BIT), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .reset_p(reset_p), .sel_ch(sel_ch), .cmd_start(cmd_start), .cmd_inc_sec(cmd_inc_sec),
    .cmd_inc_min(cmd_inc_min), .cmd_clear(cmd_clear), .alarm_off(alarm_off), .reload_mode(reload_mode),
    .value(value), .running(running), .alarm(alarm), .expired(expired), .buzz_clk(buzz_clk)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] exp_value();
    int ch;
    ch = int'(sel_ch);
    if (m_state[ch] == M_IDLE) return to_bcd(m_smin[ch] * 60 + m_ssec[ch]);
    return to_bcd(m_cur[ch]);
  endfunction

  function automatic logic [N_CH-1:0] exp_state_vec(input int st);
    logic [N_CH-1:0] r;
    for (int ch = 0; ch < N_CH; ch++) r[ch] = (m_state[ch] == st);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_expired();
    logic [N_CH-1:0] r;
    for (int ch = 0; ch < N_CH; ch++) r[ch] = m_exp[ch];
    return r;
  endfunction

  function automatic logic exp_buzz();
    if (exp_state_vec(M_ALARM) == '0) return 1'b0;
    return 1'((m_ps >> BUZZ_BIT) & 1);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_state[ch] = M_IDLE; m_smin[ch] = 0; m_ssec[ch] = 0; m_cur[ch] = 0;
      m_ring[ch] = 0; m_pend[ch] = 0; m_exp[ch] = 0;
    end
    m_ps = 0;
    m_tick = 0;
  endtask

  task automatic model_step();
    int top;
    m_tick = (m_ps == TICK_DIV - 1);
    m_ps = m_tick ? 0 : m_ps + 1;
    top = cmd_clear ? K_CLEAR : cmd_start ? K_START : cmd_inc_min ? K_INC_MIN :
          cmd_inc_sec ? K_INC_SEC : alarm_off ? K_ALARM_OFF : K_NONE;
    for (int ch = 0; ch < N_CH; ch++) begin
      int c, set_s;
      bit pend_now;
      c = (ch == int'(sel_ch)) ? top : K_NONE;
      set_s = m_smin[ch] * 60 + m_ssec[ch];
      m_exp[ch] = 0;
      if (c == K_CLEAR) begin
        m_state[ch] = M_IDLE;
        m_pend[ch] = 0;
      end else begin
        pend_now = m_pend[ch];
        m_pend[ch] = 0;
        if (pend_now) m_cur[ch] = set_s;
        case (m_state[ch])
          M_IDLE: begin
            if (c == K_START) begin
              if (set_s != 0) begin m_cur[ch] = set_s; m_state[ch] = M_RUN; end
            end else if (c == K_INC_MIN) m_smin[ch] = (m_smin[ch] + 1) % 60;
            else if (c == K_INC_SEC) m_ssec[ch] = (m_ssec[ch] + 1) % 60;
          end
          M_RUN: begin
            if (c == K_START) m_state[ch] = M_PAUSE;
            else if (m_tick && !pend_now) begin
              m_cur[ch] = m_cur[ch] - 1;
              if (m_cur[ch] == 0) begin
                m_exp[ch] = 1;
                if (reload_mode[ch]) m_pend[ch] = 1;
                else begin m_state[ch] = M_ALARM; m_ring[ch] = 0; end
              end
            end
          end
          M_PAUSE: if (c == K_START) m_state[ch] = M_RUN;
          default: begin
            if (c == K_START || c == K_ALARM_OFF) m_state[ch] = M_IDLE;
            else if (m_tick) begin
              m_ring[ch] = m_ring[ch] + 1;
              if (m_ring[ch] == ALARM_SEC) m_state[ch] = M_IDLE;
            end
          end
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < N_CH; ch++) if (expired[ch] === 1'b1) exp_cnt[ch]++;
    if (buzz_clk === 1'b1) buzz_hi = 1; else buzz_lo = 1;
  endtask

  task automatic wait_tick();
    do step(); while (!m_tick);
  endtask

  task automatic cmd(input int kind, input int ch);
    sel_ch = 2'(ch);
    cmd_clear = (kind == K_CLEAR); cmd_start = (kind == K_START); cmd_inc_min = (kind == K_INC_MIN);
    cmd_inc_sec = (kind == K_INC_SEC); alarm_off = (kind == K_ALARM_OFF);
    step();
    cmd_clear = 0; cmd_start = 0; cmd_inc_min = 0; cmd_inc_sec = 0; alarm_off = 0;
  endtask

  task automatic do_reset();
    reset_p = 1;
    model_reset();
    for (int ch = 0; ch < N_CH; ch++) exp_cnt[ch] = 0;
    #2;
    reset_p = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (value !== 16'h0000) begin n_err++; $display("FAIL reset_value: got %h want 0000", value); end
    n_cmp++; if (running !== 4'h0) begin n_err++; $display("FAIL reset_running: got %b want 0000", running); end
    n_cmp++; if (alarm !== 4'h0) begin n_err++; $display("FAIL reset_alarm: got %b want 0000", alarm); end
    n_cmp++; if (expired !== 4'h0) begin n_err++; $display("FAIL reset_expired: got %b want 0000", expired); end
    n_cmp++; if (buzz_clk !== 1'b0) begin n_err++; $display("FAIL reset_buzz: got %b want 0", buzz_clk); end
  endtask

  task automatic test_basic();
    repeat (3) cmd(K_INC_SEC, 0);
    n_cmp++; if (value !== 16'h0003) begin n_err++; $display("FAIL basic_set: got %h want 0003", value); end
    cmd(K_START, 0);
    n_cmp++; if (running[0] !== 1'b1) begin n_err++; $display("FAIL basic_running: got %b want 1", running[0]); end
    wait_tick();
    n_cmp++; if (value !== 16'h0002) begin n_err++; $display("FAIL basic_t1: got %h want 0002", value); end
    wait_tick();
    n_cmp++; if (value !== 16'h0001) begin n_err++; $display("FAIL basic_t2: got %h want 0001", value); end
    wait_tick();
    n_cmp++; if (value !== 16'h0000) begin n_err++; $display("FAIL basic_t3: got %h want 0000", value); end
    n_cmp++; if (expired[0] !== 1'b1) begin n_err++; $display("FAIL basic_expired: got %b want 1", expired[0]); end
    n_cmp++; if (alarm[0] !== 1'b1) begin n_err++; $display("FAIL basic_alarm_on: got %b want 1", alarm[0]); end
    buzz_hi = 0; buzz_lo = 0;
    wait_tick(); wait_tick();
    n_cmp++; if (alarm[0] !== 1'b1) begin n_err++; $display("FAIL basic_alarm_hold: got %b want 1", alarm[0]); end
    n_cmp++; if ({buzz_hi, buzz_lo} !== 2'b11) begin n_err++; $display("FAIL basic_buzz_toggle: hi/lo seen %b%b want 11", buzz_hi, buzz_lo); end
    wait_tick();
    n_cmp++; if (alarm[0] !== 1'b0) begin n_err++; $display("FAIL basic_alarm_off: got %b want 0", alarm[0]); end
    n_cmp++; if (value !== 16'h0003) begin n_err++; $display("FAIL basic_idle_value: got %h want 0003", value); end
    n_cmp++; if (exp_cnt[0] != 1) begin n_err++; $display("FAIL basic_expired_count: got %0d want 1", exp_cnt[0]); end
    n_cmp++; if (buzz_clk !== 1'b0) begin n_err++; $display("FAIL basic_buzz_quiet: got %b want 0", buzz_clk); end
  endtask

  task automatic test_pause();
    cmd(K_INC_MIN, 1);
    n_cmp++; if (value !== 16'h0100) begin n_err++; $display("FAIL pause_set: got %h want 0100", value); end
    cmd(K_START, 1);
    wait_tick();
    n_cmp++; if (value !== 16'h0059) begin n_err++; $display("FAIL pause_borrow: got %h want 0059", value); end
    cmd(K_START, 1);
    n_cmp++; if (running[1] !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want 0", running[1]); end
    repeat (50) step();
    n_cmp++; if (value !== 16'h0059) begin n_err++; $display("FAIL pause_frozen: got %h want 0059", value); end
    cmd(K_START, 1);
    n_cmp++; if (running[1] !== 1'b1) begin n_err++; $display("FAIL pause_resume: got %b want 1", running[1]); end
    wait_tick();
    n_cmp++; if (value !== 16'h0058) begin n_err++; $display("FAIL pause_next: got %h want 0058", value); end
    cmd(K_CLEAR, 1);
    n_cmp++; if (value !== 16'h0100) begin n_err++; $display("FAIL pause_clear: got %h want 0100", value); end
  endtask

  task automatic test_reload();
    reload_mode = 4'b0100;
    repeat (2) cmd(K_INC_SEC, 2);
    cmd(K_START, 2);
    exp_cnt[2] = 0;
    for (int p = 0; p < 3; p++) begin
      wait_tick();
      n_cmp++; if (value !== 16'h0001) begin n_err++; $display("FAIL reload_p%0d_one: got %h want 0001", p, value); end
      wait_tick();
      n_cmp++; if ({value, expired[2]} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL reload_p%0d_zero: value/exp %h/%b want 0000/1", p, value, expired[2]); end
      step();
      n_cmp++; if (value !== 16'h0002) begin n_err++; $display("FAIL reload_p%0d_reload: got %h want 0002", p, value); end
      n_cmp++; if ({running[2], alarm[2]} !== 2'b10) begin n_err++; $display("FAIL reload_p%0d_state: run/alarm %b%b want 10", p, running[2], alarm[2]); end
    end
    n_cmp++; if (exp_cnt[2] != 3) begin n_err++; $display("FAIL reload_count: got %0d want 3", exp_cnt[2]); end
    cmd(K_CLEAR, 2);
    reload_mode = '0;
  endtask

  task automatic test_concurrent();
    bit both;
    repeat (5) cmd(K_INC_SEC, 3);
    exp_cnt[0] = 0; exp_cnt[3] = 0;
    cmd(K_START, 3);
    cmd(K_START, 0);
    both = 0;
    for (int i = 0; i < 200 && !both; i++) begin
      sel_ch = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      step();
      n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL conc_value ch%0d: got %h want %h", sel_ch, value, exp_value()); end
      both = (m_state[0] == M_ALARM) && (m_state[3] == M_ALARM);
    end
    n_cmp++; if (!both) begin n_err++; $display("FAIL conc_overlap: model never saw both alarms within budget"); end
    n_cmp++; if ({alarm[3], alarm[0]} !== 2'b11) begin n_err++; $display("FAIL conc_both_alarm: got %b%b want 11", alarm[3], alarm[0]); end
    cmd(K_ALARM_OFF, 3);
    n_cmp++; if ({alarm[3], alarm[0]} !== 2'b01) begin n_err++; $display("FAIL conc_alarm_off3: a3/a0 %b%b want 01", alarm[3], alarm[0]); end
    for (int i = 0; i < 100 && m_state[0] != M_IDLE; i++) step();
    n_cmp++; if (alarm[0] !== 1'b0) begin n_err++; $display("FAIL conc_ch0_clear: got %b want 0", alarm[0]); end
    n_cmp++; if ({exp_cnt[0], exp_cnt[3]} != {32'd1, 32'd1}) begin n_err++; $display("FAIL conc_expired: ch0 %0d ch3 %0d want 1 1", exp_cnt[0], exp_cnt[3]); end
  endtask

  task automatic test_edges();
    do_reset();
    cmd(K_START, 2);
    n_cmp++; if ({running, alarm, value} !== {4'h0, 4'h0, 16'h0000}) begin n_err++; $display("FAIL edge_zero_start: run %b alarm %b value %h want 0/0/0000", running, alarm, value); end
    cmd(K_INC_MIN, 1);
    repeat (59) cmd(K_INC_SEC, 1);
    n_cmp++; if (value !== 16'h0159) begin n_err++; $display("FAIL edge_sec59: got %h want 0159", value); end
    cmd(K_INC_SEC, 1);
    n_cmp++; if (value !== 16'h0100) begin n_err++; $display("FAIL edge_sec_wrap: got %h want 0100", value); end
    repeat (2) cmd(K_INC_SEC, 0);
    cmd(K_START, 0);
    wait_tick();
    n_cmp++; if (value !== 16'h0001) begin n_err++; $display("FAIL edge_at_one: got %h want 0001", value); end
    while (m_ps != TICK_DIV - 1) step();
    cmd(K_CLEAR, 0);
    n_cmp++; if ({running[0], alarm[0], expired[0]} !== 3'b000) begin n_err++; $display("FAIL edge_clear_tick: run/alarm/exp %b%b%b want 000", running[0], alarm[0], expired[0]); end
    n_cmp++; if (value !== 16'h0002) begin n_err++; $display("FAIL edge_clear_value: got %h want 0002", value); end
    n_cmp++; if (exp_cnt[0] != 0) begin n_err++; $display("FAIL edge_clear_noexp: got %0d want 0", exp_cnt[0]); end
  endtask

  task automatic test_reset_mid();
    cmd(K_START, 1);
    cmd(K_START, 0);
    wait_tick(); wait_tick();
    n_cmp++; if ({alarm, running} !== {4'b0001, 4'b0010}) begin n_err++; $display("FAIL rmid_pre: alarm %b running %b want 0001 0010", alarm, running); end
    repeat (3) step();
    reset_p = 1;
    #1;
    n_cmp++; if ({value, running, alarm, expired, buzz_clk} !== 29'd0) begin n_err++; $display("FAIL rmid_outputs: value %h run %b alarm %b exp %b buzz %b want all 0", value, running, alarm, expired, buzz_clk); end
    model_reset();
    #1;
    reset_p = 0;
    step();
    sel_ch = 2'd0; #1;
    n_cmp++; if (value !== 16'h0000) begin n_err++; $display("FAIL rmid_set0: got %h want 0000", value); end
    sel_ch = 2'd1; #1;
    n_cmp++; if (value !== 16'h0000) begin n_err++; $display("FAIL rmid_set1: got %h want 0000", value); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sel_ch      = 2'($urandom_range(0, N_CH - 1));
      cmd_start   = ($urandom_range(0, 11) == 0);
      cmd_inc_sec = ($urandom_range(0, 5) == 0);
      cmd_inc_min = ($urandom_range(0, 59) == 0);
      cmd_clear   = ($urandom_range(0, 39) == 0);
      alarm_off   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) reload_mode = 4'($urandom);
      step();
      n_cmp++; if (value !== exp_value()) begin n_err++; $display("FAIL rnd_value @%0d: got %h want %h", i, value, exp_value()); end
      n_cmp++; if (running !== exp_state_vec(M_RUN)) begin n_err++; $display("FAIL rnd_running @%0d: got %b want %b", i, running, exp_state_vec(M_RUN)); end
      n_cmp++; if (alarm !== exp_state_vec(M_ALARM)) begin n_err++; $display("FAIL rnd_alarm @%0d: got %b want %b", i, alarm, exp_state_vec(M_ALARM)); end
      n_cmp++; if (expired !== exp_expired()) begin n_err++; $display("FAIL rnd_expired @%0d: got %b want %b", i, expired, exp_expired()); end
      n_cmp++; if (buzz_clk !== exp_buzz()) begin n_err++; $display("FAIL rnd_buzz @%0d: got %b want %b", i, buzz_clk, exp_buzz()); end
    end
    cmd_start = 0; cmd_inc_sec = 0; cmd_inc_min = 0; cmd_clear = 0; alarm_off = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_reload();
    test_concurrent();
    test_edges();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
